// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Single-bit full adder, purely combinational; sequenced by serial_add_ctrl.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell per cycle, LSB first.
// Optional signed-overflow output ovf is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // the producer holds its data while valid is high and ready is low.

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          sum_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        if (cnt_q == LAST) begin
          // carry_q is the carry into the MSB on this final cell
          state_d = DONE;
          ovf_d   = carry_q ^ fa_co;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      a_d     = '0;
      b_d     = '0;
      sum_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
    end
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign cout      = carry_q;
  assign state_dbg = state_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl (WIDTH = 4) against an arithmetic model with a result queue.
module tb_serial_add_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, clear, in_valid, out_ready, cin;
  logic [W-1:0] a_in, b_in;
  logic         in_ready, out_valid, cout;
  logic [W-1:0] sum_out;
  logic [1:0]   state_dbg;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int pass_cnt  = 0;
  int check_cnt = 0;
  bit chk_en    = 1'b0;

  // model state: result queue entries are {ovf, cout, sum}
  logic [W+1:0] exp_q[$];
  bit           m_idle  = 1'b1;
  bit           m_valid = 1'b0;
  int           m_wait  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout      (cout),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .state_dbg (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // reference model: result = a + b + cin, available W cycles after acceptance
  always @(posedge clk) begin
    logic [W:0] full;
    logic       sovf;
    if (!rst_n) begin
      m_idle = 1'b1; m_valid = 1'b0; m_wait = 0; exp_q.delete();
    end else if (clear) begin
      m_idle = 1'b1; m_valid = 1'b0; m_wait = 0; exp_q.delete();
    end else if (m_idle) begin
      if (in_valid) begin
        full = {1'b0, a_in} + {1'b0, b_in} + (W+1)'(cin);
        sovf = (a_in[W-1] == b_in[W-1]) && (full[W-1] != a_in[W-1]);
        exp_q.push_back({sovf, full});
        m_idle = 1'b0;
        m_wait = W;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
      m_idle  = 1'b1;
      void'(exp_q.pop_front());
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_in_ready", in_ready, m_idle);
      chk("model_out_valid", out_valid, m_valid);
      if (m_valid && exp_q.size() > 0) begin
        chk("model_sum", sum_out, exp_q[0][W-1:0]);
        chk("model_cout", cout, exp_q[0][W]);
`ifdef SERIAL_ADD_OVF_EN
        chk("model_ovf", ovf, exp_q[0][W+1]);
`endif
      end
    end
  end

  // driver: one operation with literal expectations and an optional back-pressure hold
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int hold, input logic [W-1:0] es, input logic ec, input logic eo);
    int g;
    int lat;
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    chk("op_in_ready", in_ready, 1);
    in_valid = 1'b1; a_in = a; b_in = b; cin = c;
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("op_latency", lat, W);
    chk("op_sum", sum_out, es);
    chk("op_cout", cout, ec);
`ifdef SERIAL_ADD_OVF_EN
    chk("op_ovf", ovf, eo);
`else
    if (eo !== eo) chk("op_ovf_x", eo, 0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      chk("hold_sum", sum_out, es);
      chk("hold_cout", cout, ec);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cin = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum_out, 0);
    chk("reset_cout", cout, 0);
    chk("reset_state", state_dbg, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op(4'd3, 4'd5, 1'b0, 0, 4'd8, 1'b0, 1'b1);
    run_op(4'd15, 4'd1, 1'b0, 0, 4'd0, 1'b1, 1'b0);
    run_op(4'd0, 4'd0, 1'b1, 0, 4'd1, 1'b0, 1'b0);
    run_op(4'd9, 4'd9, 1'b0, 5, 4'd2, 1'b1, 1'b1);

    // reset after three bits have been processed
    @(negedge clk);
    in_valid = 1'b1; a_in = 4'd9; b_in = 4'd3; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum_out, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_state", state_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd6, 4'd7, 1'b0, 0, 4'd13, 1'b0, 1'b1);

    // clear during RUN discards the operation
    @(negedge clk);
    in_valid = 1'b1; a_in = 4'd5; b_in = 4'd5; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    chk("clear_in_ready", in_ready, 1);
    chk("clear_out_valid", out_valid, 0);
    @(negedge clk);
    clear = 1'b0;
    repeat (W + 2) @(negedge clk);
    chk("clear_no_valid", out_valid, 0);

`ifdef SERIAL_ADD_OVF_EN
    run_op(4'd7, 4'd1, 1'b0, 0, 4'd8, 1'b0, 1'b1);
    run_op(4'd8, 4'd8, 1'b0, 0, 4'd0, 1'b1, 1'b1);
    run_op(4'd3, 4'd2, 1'b0, 0, 4'd5, 1'b0, 1'b0);
`endif

    // randomized traffic with back-pressure and occasional clear
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = 1'($urandom_range(0, 1));
      a_in      = W'($urandom);
      b_in      = W'($urandom);
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      clear     = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
